// File: rtl/and_gate_core.sv
// Bitwise AND with combinational and registered results plus a rising-edge pulse on the all-ones condition.
// Optional rise counter with clear is built only when AND_GATE_STATS_EN is defined.
module and_gate_core #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic             y_all,
  output logic [WIDTH-1:0] y_q,
  output logic             y_rise,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] rise_cnt
);

  logic [WIDTH-1:0] y_d;
  logic             all_q, all_d;
  logic             y_rise_q, y_rise_d;
  logic             rise_ev;

  assign Y       = A & B;
  assign y_all   = &Y;
  assign rise_ev = y_all & ~all_q;
  assign y_rise  = y_rise_q;

  always_comb begin
    y_d      = Y;
    all_d    = y_all;
    y_rise_d = rise_ev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q      <= '0;
      all_q    <= 1'b0;
      y_rise_q <= 1'b0;
    end else begin
      y_q      <= y_d;
      all_q    <= all_d;
      y_rise_q <= y_rise_d;
    end
  end

`ifdef AND_GATE_STATS_EN
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;

  // Clear wins over a same-edge rise; the count sticks at all-ones rather than wrapping.
  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (cnt_clr) begin
      rise_cnt_d = '0;
    end else if (rise_ev && (rise_cnt_q != {CNT_W{1'b1}})) begin
      rise_cnt_d = rise_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_cnt_q <= '0;
    end else begin
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign rise_cnt = rise_cnt_q;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign rise_cnt       = '0;
`endif

endmodule

// File: tb/tb_and_gate_core.sv
// Scoreboard bench for and_gate_core: a 4-bit instance with a 3-bit counter and a 1-bit instance on bit 0.
// Registered expectations are queued by the stimulus and checked by an independent monitor after each edge.
module tb_and_gate_core;

  typedef struct {
    logic [3:0] yq;
    logic       rise;
    logic [2:0] cnt;
    logic       yq1;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cnt_clr;
  logic [3:0] a_in, b_in;
  logic [3:0] y_w4, yq_w4;
  logic       yall_w4, rise_w4;
  logic [2:0] cnt_w4;
  logic [0:0] y_w1, yq_w1;
  logic       yall_w1, rise_w1;
  logic [1:0] cnt_w1;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  and_gate_core #(.WIDTH(4), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .A(a_in), .B(b_in), .Y(y_w4), .y_all(yall_w4),
    .y_q(yq_w4), .y_rise(rise_w4), .cnt_clr(cnt_clr), .rise_cnt(cnt_w4)
  );

  and_gate_core #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst(rst), .A(a_in[0:0]), .B(b_in[0:0]), .Y(y_w1), .y_all(yall_w1),
    .y_q(yq_w1), .y_rise(rise_w1), .cnt_clr(cnt_clr), .rise_cnt(cnt_w1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one vector away from the edge, checks the combinational outputs, and queues the registered result.
  task automatic applyStimulus(input logic r, input logic c, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] expY, input logic expRise, input logic [2:0] expCntOn);
    exp_t e;
    @(negedge clk);
    rst     = r;
    cnt_clr = c;
    a_in    = a;
    b_in    = b;
    #1;
    checkOutput("Y", {28'd0, y_w4}, {28'd0, expY});
    checkOutput("y_all", {31'd0, yall_w4}, {31'd0, (expY == 4'hF)});
    checkOutput("Y_w1", {31'd0, y_w1}, {31'd0, expY[0]});
    e.yq   = r ? 4'h0 : expY;
    e.rise = r ? 1'b0 : expRise;
`ifdef AND_GATE_STATS_EN
    e.cnt  = expCntOn;
`else
    e.cnt  = 3'd0;
`endif
    e.yq1  = r ? 1'b0 : expY[0];
    expQ.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("y_q", {28'd0, yq_w4}, {28'd0, e.yq});
        checkOutput("y_rise", {31'd0, rise_w4}, {31'd0, e.rise});
        checkOutput("rise_cnt", {29'd0, cnt_w4}, {29'd0, e.cnt});
        checkOutput("y_q_w1", {31'd0, yq_w1}, {31'd0, e.yq1});
      end
    end
  end

  initial begin
    rst     = 1'b1;
    cnt_clr = 1'b0;
    a_in    = 4'h0;
    b_in    = 4'h0;

    // Reset held two cycles with all-ones operands, then release.
    applyStimulus(1, 0, 4'hF, 4'hF, 4'hF, 0, 3'd0);
    applyStimulus(1, 0, 4'hF, 4'hF, 4'hF, 0, 3'd0);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd1);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 0, 3'd1);
    applyStimulus(0, 0, 4'hF, 4'h0, 4'h0, 0, 3'd1);
    applyStimulus(0, 0, 4'hF, 4'hB, 4'hB, 0, 3'd1);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd2);

    // y_all pattern 0,1,1,1,0,1 plus mixed operands.
    applyStimulus(0, 0, 4'h0, 4'hF, 4'h0, 0, 3'd2);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd3);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 0, 3'd3);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 0, 3'd3);
    applyStimulus(0, 0, 4'h5, 4'hF, 4'h5, 0, 3'd3);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd4);
    applyStimulus(0, 0, 4'h3, 4'h6, 4'h2, 0, 3'd4);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd5);
    applyStimulus(0, 0, 4'hC, 4'hA, 4'h8, 0, 3'd5);

    // Clear on the same edge as a rise leaves the count at zero.
    applyStimulus(0, 1, 4'hF, 4'hF, 4'hF, 1, 3'd0);
    applyStimulus(0, 0, 4'h0, 4'h0, 4'h0, 0, 3'd0);

    // Nine rises into a 3-bit counter: stops at 7.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, (k > 7) ? 3'd7 : 3'(k));
      applyStimulus(0, 0, 4'h0, 4'hF, 4'h0, 0, (k > 7) ? 3'd7 : 3'(k));
    end
    applyStimulus(0, 1, 4'h0, 4'h0, 4'h0, 0, 3'd0);

    // Reset in the middle of a held-high run; the first edge afterwards counts again.
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd1);
    applyStimulus(1, 0, 4'hF, 4'hF, 4'hF, 0, 3'd0);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 1, 3'd1);
    applyStimulus(0, 0, 4'hF, 4'hF, 4'hF, 0, 3'd1);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
